// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM states and operation mode.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder with optional B inversion, used for serial add/subtract.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic inv,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic bb;

  assign bb   = b ^ inv;
  assign s    = a ^ bb ^ cin;
  assign cout = (a & bb) | (a & cin) | (bb & cin);

endmodule

// File: rtl/serial_addsub_w.sv
// W-bit bit-serial adder/subtractor, LSB first, with start/done framing and flags.
// Optional parallel result output enabled by defining SERIAL_ADDSUB_PAR_OUT_EN.
module serial_addsub_w
  import serial_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         in_valid,
  input  logic         a,
  input  logic         b,
  output logic         s,
  output logic         s_valid,
  output logic         busy,
  output logic         done,
  output logic         cout,
  output logic         ovf
`ifdef SERIAL_ADDSUB_PAR_OUT_EN
  ,
  output logic [W-1:0] sum_par
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          mode_r;
  logic          fa_s;
  logic          fa_co;
  logic          start_ok;
  logic          accept;
  logic          last;

  assign start_ok = start && (state != ST_RUN);
  assign accept   = in_valid && (state == ST_RUN);
  assign last     = (cnt == LAST);

  serial_fa_cell u_fa (
    .a    (a),
    .b    (b),
    .inv  (mode_r),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (in_valid && last) state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Subtraction preloads carry with 1 so inverted B becomes its two's complement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s       <= 1'b0;
      s_valid <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      carry   <= MODE_ADD;
      mode_r  <= MODE_ADD;
      cnt     <= '0;
    end else if (start_ok) begin
      s_valid <= 1'b0;
      carry   <= mode;
      mode_r  <= mode;
      cnt     <= '0;
    end else if (accept) begin
      s       <= fa_s;
      s_valid <= 1'b1;
      carry   <= fa_co;
      cnt     <= last ? cnt : cnt + 1'b1;
      if (last) begin
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end
    end else begin
      s_valid <= 1'b0;
    end
  end

`ifdef SERIAL_ADDSUB_PAR_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst)          sum_par <= '0;
    else if (start_ok) sum_par <= '0;
    else if (accept)   sum_par <= {fa_s, sum_par[W-1:1]};
  end
`endif

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
